stopwatch_counter_bank: RTL and testbench
=========================================

STOPWATCH_COUNTER_BANK -- requirements
Module: stopwatch_counter_bank

Interface
REQ-001 Parameter CNT_W, default 16, counter width per channel in bits (2..32).
REQ-002 Parameter N_CH, default 4, number of independent channels (1..16).
REQ-003 Parameter SATURATE, default 0: 0 = wrap on overflow, 1 = hold at maximum.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 active_event  input  N_CH  per-channel event strobe, one count per high cycle.
REQ-007 cmd_valid  input  1  qualifies flags/cmd_ch for one cycle.
REQ-008 cmd_ch  input  max(1,$clog2(N_CH))  target channel of the command.
REQ-009 flags  input  8  command: 8'h01 START, 8'h02 PAUSE, 8'h04 STOP, 8'h08 LAP; other values are no-ops.
REQ-010 cnt_events  output  N_CH*CNT_W  registered counts, channel i at bits [i*CNT_W +: CNT_W].
REQ-011 lap_value  output  N_CH*CNT_W  registered lap captures, same packing.
REQ-012 running  output  N_CH  high while the channel is in RUN.
REQ-013 overflow  output  N_CH  sticky overflow flag per channel.

Function
REQ-014 Each channel has a 3-state FSM: IDLE, RUN, PAUSED.
REQ-015 A command is accepted only when cmd_valid=1, cmd_ch<N_CH and flags is one of the four codes; otherwise nothing changes.
REQ-016 START: IDLE->RUN, PAUSED->RUN; in RUN no effect.
REQ-017 PAUSE: RUN->PAUSED; in IDLE or PAUSED no effect.
REQ-018 STOP: any state->IDLE; count, lap_value and overflow of that channel cleared to 0 on the same edge.
REQ-019 LAP: copies the channel's current cnt_events (pre-edge value) into lap_value; state and count unchanged; accepted in any state.
REQ-020 Count increments by 1 on an edge where the channel's pre-edge state is RUN and active_event[i]=1; IDLE and PAUSED hold the count.
REQ-021 Same-cycle command and event: the event is judged against the pre-edge state; STOP overrides, resulting count 0; START from IDLE/PAUSED does not count that cycle's event; PAUSE from RUN does count it.
REQ-022 At count 2^CNT_W-1 with a counted event: SATURATE=0 -> count becomes 0; SATURATE=1 -> count holds at max; in both, overflow[i] sets on that edge.
REQ-023 overflow[i] stays set until STOP on channel i or reset.
REQ-024 Channels are fully independent; a command on one channel never alters another.
REQ-025 All outputs are registered; latency from accepted command or event to output change is exactly one clock edge.
REQ-026 running[i] is 1 exactly when the registered state is RUN.

Reset
REQ-027 While rst=1, asynchronously: all FSMs IDLE, cnt_events=0, lap_value=0, running=0, overflow=0.
REQ-028 rst asserted mid-count discards all in-progress state; after deassertion channels need START to count again.
REQ-029 No command or event is acted on during a cycle in which rst=1 at the rising edge.

Verification
REQ-030 Reset, START ch0, 5 cycles active_event[0]=1 -> cnt ch0 = 5, running[0]=1, other channels 0.
REQ-031 CNT_W=4, SATURATE=0, RUN, 17 events -> count 0..15 then 0 then 1, overflow[0]=1 from 16th event; STOP -> count 0, overflow 0.
REQ-032 CNT_W=4, SATURATE=1, 20 events -> count holds 15, overflow=1.
REQ-033 Count 7, PAUSE with event same cycle -> count 8 then holds over 3 further events; START -> resumes at 8; LAP at 10 -> lap_value=10, count continues.
REQ-034 START ch2 and event[2] same cycle -> count 0 next cycle; STOP ch2 with event[2] at count 9 -> count 0, IDLE.
REQ-035 rst pulsed asynchronously between edges at count 12, ch1 RUN -> outputs 0 immediately; flags=8'h03 and cmd_ch=N_CH after release -> no state change.

Source files
------------

// File: rtl/stopwatch_counter_bank_if.sv
// Stopwatch counter bank bus: per-channel event strobes, a one-cycle
// command port, and the registered count/lap/status outputs.
//
// Handshake: the command port has no ready. A command is a single cycle
// with cmd_valid=1. The bank always accepts it on that rising edge when
// cmd_ch names an existing channel and flags holds one of the four command
// codes. Any other combination is ignored. Outputs carry no valid; they are
// registered and meaningful on every cycle.
//
// The N_CH/CNT_W values must match the parameters of the connected bank.
interface stopwatch_counter_bank_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]       active_event;
    logic                  cmd_valid;
    logic [CH_W-1:0]       cmd_ch;
    logic [7:0]            flags;
    logic [N_CH*CNT_W-1:0] cnt_events;
    logic [N_CH*CNT_W-1:0] lap_value;
    logic [N_CH-1:0]       running;
    logic [N_CH-1:0]       overflow;
    // Per-channel FSM state, 2 bits each, for observation only.
    logic [2*N_CH-1:0]     dbg_state;

    modport master (
        output active_event, cmd_valid, cmd_ch, flags,
        input  cnt_events, lap_value, running, overflow, dbg_state
    );

    modport slave (
        input  active_event, cmd_valid, cmd_ch, flags,
        output cnt_events, lap_value, running, overflow, dbg_state
    );
endinterface

// File: rtl/stopwatch_counter_bank.sv
// Bank of N_CH independent stopwatch counters. Each channel has an
// IDLE/RUN/PAUSED state machine. A channel counts active_event strobes
// while it is in RUN. It can snapshot its count into a lap register. On
// overflow it either wraps or saturates, and it latches a sticky overflow
// flag.
module stopwatch_counter_bank #(
    parameter int CNT_W    = 16,
    parameter int N_CH     = 4,
    parameter int SATURATE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    stopwatch_counter_bank_if.slave io_bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;

    localparam logic [7:0] CMD_START = 8'h01;
    localparam logic [7:0] CMD_PAUSE = 8'h02;
    localparam logic [7:0] CMD_STOP  = 8'h04;
    localparam logic [7:0] CMD_LAP   = 8'h08;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Registered per-channel state.
    logic [1:0]       r_state [N_CH];
    logic [CNT_W-1:0] r_cnt   [N_CH];
    logic [CNT_W-1:0] r_lap   [N_CH];
    logic [N_CH-1:0]  r_ovf;

    // Command decode.
    logic             w_code_ok;
    logic             w_ch_ok;
    logic             w_accept;
    logic [N_CH-1:0]  w_start;
    logic [N_CH-1:0]  w_pause;
    logic [N_CH-1:0]  w_stop;
    logic [N_CH-1:0]  w_lap;

    // Next-state values.
    logic [1:0]       w_state_nxt [N_CH];
    logic [CNT_W-1:0] w_cnt_nxt   [N_CH];
    logic [CNT_W-1:0] w_lap_nxt   [N_CH];
    logic [N_CH-1:0]  w_ovf_nxt;

    // Flattened outputs.
    logic [N_CH*CNT_W-1:0] w_cnt_flat;
    logic [N_CH*CNT_W-1:0] w_lap_flat;
    logic [N_CH-1:0]       w_running;
    logic [2*N_CH-1:0]     w_dbg_state;

    // Validate the command and steer it to a single channel as one strobe per code.
    always_comb begin
        w_code_ok = (io_bus.flags == CMD_START) || (io_bus.flags == CMD_PAUSE) ||
                    (io_bus.flags == CMD_STOP)  || (io_bus.flags == CMD_LAP);
        // This check matters when N_CH is not a power of two.
        w_ch_ok   = (32'(io_bus.cmd_ch) < 32'(N_CH));
        w_accept  = io_bus.cmd_valid && w_ch_ok && w_code_ok;
        w_start   = '0;
        w_pause   = '0;
        w_stop    = '0;
        w_lap     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_accept && (io_bus.cmd_ch == CH_W'(i))) begin
                w_start[i] = (io_bus.flags == CMD_START);
                w_pause[i] = (io_bus.flags == CMD_PAUSE);
                w_stop[i]  = (io_bus.flags == CMD_STOP);
                w_lap[i]   = (io_bus.flags == CMD_LAP);
            end
        end
    end

    // Per-channel next state. Events are judged against the pre-edge state. STOP wins over everything.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_lap_nxt[i]   = r_lap[i];
            w_ovf_nxt[i]   = r_ovf[i];

            if ((r_state[i] == ST_RUN) && io_bus.active_event[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_ovf_nxt[i] = 1'b1;
                    w_cnt_nxt[i] = (SATURATE != 0) ? CNT_MAX : '0;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end

            // The lap register captures the count as it was before this edge.
            if (w_lap[i]) begin
                w_lap_nxt[i] = r_cnt[i];
            end

            case (r_state[i])
                ST_IDLE:   if (w_start[i]) w_state_nxt[i] = ST_RUN;
                ST_RUN:    if (w_pause[i]) w_state_nxt[i] = ST_PAUSED;
                ST_PAUSED: if (w_start[i]) w_state_nxt[i] = ST_RUN;
                default:   w_state_nxt[i] = ST_IDLE;
            endcase

            if (w_stop[i]) begin
                w_state_nxt[i] = ST_IDLE;
                w_cnt_nxt[i]   = '0;
                w_lap_nxt[i]   = '0;
                w_ovf_nxt[i]   = 1'b0;
            end
        end
    end

    // State, count, lap and overflow registers. Asynchronous reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
                r_lap[i]   <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
                r_lap[i]   <= w_lap_nxt[i];
            end
            r_ovf <= w_ovf_nxt;
        end
    end

    // Pack per-channel registers onto the flat output buses.
    always_comb begin
        w_cnt_flat  = '0;
        w_lap_flat  = '0;
        w_running   = '0;
        w_dbg_state = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_cnt_flat[i*CNT_W +: CNT_W] = r_cnt[i];
            w_lap_flat[i*CNT_W +: CNT_W] = r_lap[i];
            w_running[i]                 = (r_state[i] == ST_RUN);
            w_dbg_state[2*i +: 2]        = r_state[i];
        end
    end

    assign io_bus.cnt_events = w_cnt_flat;
    assign io_bus.lap_value  = w_lap_flat;
    assign io_bus.running    = w_running;
    assign io_bus.overflow   = r_ovf;
    assign io_bus.dbg_state  = w_dbg_state;
endmodule

// File: tb/tb_stopwatch_counter_bank.sv
// Testbench for stopwatch_counter_bank. Two banks (wrap and saturate) get
// identical stimulus. Each cycle, a behavioural model predicts the full
// output bundle of each bank. A negedge monitor compares those predictions
// against the banks.
module tb_stopwatch_counter_bank;
  localparam int N_CH  = 3;
  localparam int CNT_W = 4;
  localparam int MAXV  = (1 << CNT_W) - 1;
  localparam int W     = 2*N_CH*CNT_W + 2*N_CH;

  logic clk;
  logic rst;

  stopwatch_counter_bank_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus0 ();
  stopwatch_counter_bank_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus1 ();

  stopwatch_counter_bank #(.CNT_W(CNT_W), .N_CH(N_CH), .SATURATE(0)) u_dut_wrap (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus0)
  );

  stopwatch_counter_bank #(.CNT_W(CNT_W), .N_CH(N_CH), .SATURATE(1)) u_dut_sat (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus1)
  );

  typedef enum int {M_IDLE, M_RUN, M_PAUSED} mode_t;

  mode_t m_mode [2][N_CH];
  int    m_cnt  [2][N_CH];
  int    m_lap  [2][N_CH];
  bit    m_ovf  [2][N_CH];

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N_CH; c++) begin
        m_mode[d][c] = M_IDLE;
        m_cnt[d][c]  = 0;
        m_lap[d][c]  = 0;
        m_ovf[d][c]  = 1'b0;
      end
    end
  endtask

  // d=0 is the wrapping bank, d=1 the saturating bank.
  task automatic model_step(input int d, input logic [N_CH-1:0] act, input logic v,
                            input int ch, input int fl);
    bit is_cmd;
    int nc;
    is_cmd = v && (ch < N_CH) && (fl == 1 || fl == 2 || fl == 4 || fl == 8);
    for (int c = 0; c < N_CH; c++) begin
      nc = m_cnt[d][c];
      if (m_mode[d][c] == M_RUN && act[c]) begin
        if (nc == MAXV) begin
          m_ovf[d][c] = 1'b1;
          nc = (d == 1) ? MAXV : 0;
        end else begin
          nc = nc + 1;
        end
      end
      if (is_cmd && ch == c) begin
        case (fl)
          1: if (m_mode[d][c] != M_RUN) m_mode[d][c] = M_RUN;
          2: if (m_mode[d][c] == M_RUN) m_mode[d][c] = M_PAUSED;
          4: begin
            m_mode[d][c] = M_IDLE;
            nc = 0;
            m_lap[d][c] = 0;
            m_ovf[d][c] = 1'b0;
          end
          8: m_lap[d][c] = m_cnt[d][c];
          default: ;
        endcase
      end
      m_cnt[d][c] = nc;
    end
  endtask

  function automatic logic [W-1:0] model_vec(input int d);
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < N_CH; c++) begin
      v[c*CNT_W +: CNT_W]             = CNT_W'(m_cnt[d][c]);
      v[N_CH*CNT_W + c*CNT_W +: CNT_W] = CNT_W'(m_lap[d][c]);
      v[2*N_CH*CNT_W + c]             = (m_mode[d][c] == M_RUN);
      v[2*N_CH*CNT_W + N_CH + c]      = m_ovf[d][c];
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [N_CH-1:0] act, input logic v,
                       input logic [1:0] ch, input logic [7:0] fl);
    bus0.active_event = act;
    bus0.cmd_valid    = v;
    bus0.cmd_ch       = ch;
    bus0.flags        = fl;
    bus1.active_event = act;
    bus1.cmd_valid    = v;
    bus1.cmd_ch       = ch;
    bus1.flags        = fl;
    @(posedge clk);
    if (!rst) begin
      model_step(0, act, v, int'(ch), int'(fl));
      model_step(1, act, v, int'(ch), int'(fl));
    end
    exp_q0.push_back(model_vec(0));
    exp_q1.push_back(model_vec(1));
    cyc++;
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Pulse reset between clock edges, then check that the outputs cleared without an edge.
  task automatic async_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_wrap_cnt", int'(bus0.cnt_events), 0);
    chk("async_rst_wrap_lap", int'(bus0.lap_value), 0);
    chk("async_rst_wrap_run", int'(bus0.running), 0);
    chk("async_rst_sat_ovf", int'(bus1.overflow), 0);
    chk("async_rst_sat_cnt", int'(bus1.cnt_events), 0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      a = {bus0.overflow, bus0.running, bus0.lap_value, bus0.cnt_events};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL scb_wrap cycle %0d: got %h expected %h", cyc, a, e);
      end
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      a = {bus1.overflow, bus1.running, bus1.lap_value, bus1.cnt_events};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL scb_sat cycle %0d: got %h expected %h", cyc, a, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N_CH-1:0] r_act;
    logic            r_v;
    logic [1:0]      r_ch;
    logic [7:0]      r_fl;
    int              sel;

    rst = 1'b1;
    model_reset();
    // Commands and events while reset is held must be ignored.
    drive(3'b111, 1'b1, 2'd0, 8'h01);
    drive(3'b111, 1'b1, 2'd1, 8'h01);
    rst = 1'b0;
    chk("reset_running", int'(bus0.running), 0);
    chk("reset_cnt", int'(bus0.cnt_events), 0);

    // START ch0, then five events.
    drive(3'b000, 1'b1, 2'd0, 8'h01);
    repeat (5) drive(3'b001, 1'b0, 2'd0, 8'h00);
    chk("start5_cnt0", int'(bus0.cnt_events[3:0]), 5);
    chk("start5_running", int'(bus0.running), 1);
    chk("start5_others", int'(bus0.cnt_events[11:4]), 0);

    // Overflow: wrap versus saturate, then STOP clears everything.
    drive(3'b000, 1'b1, 2'd0, 8'h04);
    drive(3'b000, 1'b1, 2'd0, 8'h01);
    repeat (17) drive(3'b001, 1'b0, 2'd0, 8'h00);
    chk("wrap17_cnt0", int'(bus0.cnt_events[3:0]), 1);
    chk("wrap17_ovf0", int'(bus0.overflow[0]), 1);
    chk("sat17_cnt0", int'(bus1.cnt_events[3:0]), 15);
    repeat (3) drive(3'b001, 1'b0, 2'd0, 8'h00);
    chk("sat20_cnt0", int'(bus1.cnt_events[3:0]), 15);
    chk("sat20_ovf0", int'(bus1.overflow[0]), 1);
    drive(3'b000, 1'b1, 2'd0, 8'h04);
    chk("stop_wrap_cnt0", int'(bus0.cnt_events[3:0]), 0);
    chk("stop_wrap_ovf0", int'(bus0.overflow[0]), 0);
    chk("stop_sat_ovf0", int'(bus1.overflow[0]), 0);

    // PAUSE with a same-cycle event, hold while paused, resume, then LAP.
    drive(3'b000, 1'b1, 2'd0, 8'h01);
    repeat (7) drive(3'b001, 1'b0, 2'd0, 8'h00);
    drive(3'b001, 1'b1, 2'd0, 8'h02);
    chk("pause_cnt0", int'(bus0.cnt_events[3:0]), 8);
    repeat (3) drive(3'b001, 1'b0, 2'd0, 8'h00);
    chk("paused_hold_cnt0", int'(bus0.cnt_events[3:0]), 8);
    drive(3'b000, 1'b1, 2'd0, 8'h01);
    repeat (2) drive(3'b001, 1'b0, 2'd0, 8'h00);
    drive(3'b001, 1'b1, 2'd0, 8'h08);
    chk("lap_value0", int'(bus0.lap_value[3:0]), 10);
    chk("lap_cnt0", int'(bus0.cnt_events[3:0]), 11);

    // START with a same-cycle event does not count it. STOP with a same-cycle event clears.
    drive(3'b100, 1'b1, 2'd2, 8'h01);
    chk("start_evt_cnt2", int'(bus0.cnt_events[11:8]), 0);
    repeat (9) drive(3'b100, 1'b0, 2'd0, 8'h00);
    chk("cnt2_nine", int'(bus0.cnt_events[11:8]), 9);
    drive(3'b100, 1'b1, 2'd2, 8'h04);
    chk("stop_evt_cnt2", int'(bus0.cnt_events[11:8]), 0);
    chk("stop_evt_run2", int'(bus0.running[2]), 0);

    // Asynchronous reset mid-count, then invalid commands.
    drive(3'b000, 1'b1, 2'd1, 8'h01);
    repeat (12) drive(3'b010, 1'b0, 2'd0, 8'h00);
    chk("cnt1_twelve", int'(bus0.cnt_events[7:4]), 12);
    async_reset();
    drive(3'b010, 1'b1, 2'd1, 8'h03);
    drive(3'b010, 1'b1, 2'd3, 8'h01);
    chk("bad_cmd_running", int'(bus0.running), 0);
    chk("bad_cmd_cnt1", int'(bus0.cnt_events[7:4]), 0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      r_act = N_CH'($urandom_range(0, (1 << N_CH) - 1));
      r_v   = ($urandom_range(0, 2) == 0);
      r_ch  = 2'($urandom_range(0, 3));
      sel   = $urandom_range(0, 11);
      case (sel)
        0, 1, 2: r_fl = 8'h01;
        3, 4:    r_fl = 8'h02;
        5:       r_fl = 8'h04;
        6, 7:    r_fl = 8'h08;
        default: r_fl = 8'($urandom_range(0, 255));
      endcase
      drive(r_act, r_v, r_ch, r_fl);
      if ($urandom_range(0, 149) == 0) async_reset();
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
